// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the CPU/DMA RAM arbiter.
//   arb_state_t : arbiter FSM states
//   OWNER_*     : which master drives the RAM inputs during S_ARB
//   word_addr() : byte address -> word address (drops the lane bits)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_ARB     = 2'd0,
    S_CPU_RSP = 2'd1,
    S_DMA_RSP = 2'd2
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  // Byte masks are already lane-aligned, so bits [1:0] carry no information.
  function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/mem_arb_credit.sv
// mem_arb_credit: DMA burst credit counter.
//   clk, reset : clock, synchronous active-high reset (reset loads MAX)
//   load       : reload to MAX (a CPU slot was served)
//   dec        : consume one credit (a DMA access was served)
//   count      : current credit, 0..MAX
//   zero       : no credit left, the next arbitration must go to the CPU
module mem_arb_credit #(
  parameter  int MAX = 4,
  localparam int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= CW'(MAX);
    end else if (load) begin
      count <= CW'(MAX);
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM (1-cycle registered read)
// between the rv32i core and a secondary bus master (DMA/loader).
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_addr/cpu_wmask/cpu_wdata    CPU access, presented every cycle
//   cpu_rdata, cpu_hold             read word and stall to the core
//   dma_req/dma_addr/dma_wmask/
//   dma_wdata                       secondary master request (wmask 0 = read)
//   dma_ack, dma_rdata              completion pulse and read data
//   ram_en/ram_addr/ram_wmask/
//   ram_wdata, ram_rdata            RAM port; rdata valid the cycle after ram_en
//
// DMA handshake: the master raises dma_req with addr/wmask/wdata and holds them
// stable until dma_ack. dma_ack is a single-cycle pulse, and dma_rdata is valid
// only while dma_ack=1. Once granted, an access completes and acks even if
// dma_req has dropped in the meantime.
//
// Every access takes two cycles: S_ARB issues it, the response state returns
// the data. The DMA wins arbitration while it holds credit; credit is spent by
// each DMA access and refilled by each CPU slot, so the CPU cannot starve.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 12,
  parameter int DMA_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cpu_addr,
  input  logic [3:0]        cpu_wmask,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_hold,
  input  logic              dma_req,
  input  logic [31:0]       dma_addr,
  input  logic [3:0]        dma_wmask,
  input  logic [31:0]       dma_wdata,
  output logic              dma_ack,
  output logic [31:0]       dma_rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_wmask,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CW = $clog2(DMA_BURST_MAX + 1);

  arb_state_t  state;
  arb_state_t  state_next;
  logic        owner;
  logic        credit_load;
  logic        credit_dec;
  logic        credit_zero;
  logic [CW-1:0] credit;
  logic [31:0] sel_addr;
  logic [29:0] sel_word;
  logic [31:0] cpu_rdata_q;

  mem_arb_credit #(.MAX(DMA_BURST_MAX)) u_credit (
    .clk   (clk),
    .reset (reset),
    .load  (credit_load),
    .dec   (credit_dec),
    .count (credit),
    .zero  (credit_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_ARB;
    end else begin
      state <= state_next;
    end
  end

  // All strobes are forced idle while reset is high so that a reset landing
  // mid-transaction neither writes the RAM nor acks the DMA.
  always_comb begin
    state_next  = state;
    ram_en      = 1'b0;
    owner       = OWNER_CPU;
    cpu_hold    = 1'b1;
    dma_ack     = 1'b0;
    credit_load = 1'b0;
    credit_dec  = 1'b0;
    if (!reset) begin
      unique case (state)
        S_ARB: begin
          ram_en = 1'b1;
          if (dma_req && !credit_zero) begin
            owner      = OWNER_DMA;
            state_next = S_DMA_RSP;
          end else begin
            state_next = S_CPU_RSP;
          end
        end
        S_CPU_RSP: begin
          cpu_hold    = 1'b0;
          credit_load = 1'b1;
          state_next  = S_ARB;
        end
        S_DMA_RSP: begin
          dma_ack    = 1'b1;
          credit_dec = 1'b1;
          state_next = S_ARB;
        end
        default: state_next = S_ARB;
      endcase
    end
  end

  // RAM input mux. The wmask gate makes a CPU store hit RAM only in S_ARB,
  // even though the core keeps presenting it through S_CPU_RSP.
  assign sel_addr  = (owner == OWNER_DMA) ? dma_addr  : cpu_addr;
  assign ram_wdata = (owner == OWNER_DMA) ? dma_wdata : cpu_wdata;
  assign ram_wmask = ram_en ? ((owner == OWNER_DMA) ? dma_wmask : cpu_wmask) : 4'b0000;
  assign sel_word  = word_addr(sel_addr);
  assign ram_addr  = sel_word[ADDR_W-1:0];

  // cpu_rdata passes RAM data through in the slot the core advances on and
  // holds it afterwards, so the core never sees DMA read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata_q <= 32'h0;
    end else if (state == S_CPU_RSP) begin
      cpu_rdata_q <= ram_rdata;
    end
  end

  assign cpu_rdata = (!reset && (state == S_CPU_RSP)) ? ram_rdata : cpu_rdata_q;
  assign dma_rdata = ram_rdata;

  // Upper address bits alias onto the RAM; the credit value is only of
  // interest when probing the design.
  logic unused_bits;
  assign unused_bits = ^{sel_word[29:ADDR_W], sel_addr[1:0], credit};

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int ADDR_W = 12;
  localparam int BURST  = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int SLOT   = 2 * BURST + 2;   // longest spacing between CPU steps
  localparam int RGN    = 64;              // words used by the random test

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       cpu_addr = '0;
  logic [3:0]        cpu_wmask = '0;
  logic [31:0]       cpu_wdata = '0;
  logic [31:0]       cpu_rdata;
  logic              cpu_hold;
  logic              dma_req = 1'b0;
  logic [31:0]       dma_addr = '0;
  logic [3:0]        dma_wmask = '0;
  logic [31:0]       dma_wdata = '0;
  logic              dma_ack;
  logic [31:0]       dma_rdata;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_wmask;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DMA_BURST_MAX(BURST)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wmask (cpu_wmask),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_hold  (cpu_hold),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_wmask (dma_wmask),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_wmask (ram_wmask),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // ---------------- RAM (read-first, registered read) ----------------
  logic [31:0] ram_mem [DEPTH];
  int          ram_wr_cnt = 0;

  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= ram_mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_wmask[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      if (ram_wmask != 4'b0000) ram_wr_cnt <= ram_wr_cnt + 1;
    end
  end

  // Shadow memory of the random-test region (the reference model).
  logic [31:0] exp_mem [RGN];

  // ---------------- driver tasks ----------------
  // Leaves the bench at the negedge where reset has just been released:
  // the DUT is in its first post-reset cycle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cpu_addr  = 32'h0;  cpu_wmask = 4'hF;  cpu_wdata = 32'h5555_5555;
    dma_req   = 1'b1;   dma_addr  = 32'h8; dma_wmask = 4'hF; dma_wdata = 32'h6666_6666;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (cpu_hold !== 1'b1) begin n_errors++; $display("FAIL reset_hold: got %b expected 1", cpu_hold); end
    n_checks++; if (dma_ack !== 1'b0) begin n_errors++; $display("FAIL reset_ack: got %b expected 0", dma_ack); end
    n_checks++; if (ram_en !== 1'b0) begin n_errors++; $display("FAIL reset_ram_en: got %b expected 0", ram_en); end
    n_checks++; if (ram_wmask !== 4'b0000) begin n_errors++; $display("FAIL reset_wmask: got %b expected 0000", ram_wmask); end
    n_checks++; if (cpu_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_cpu_rdata: got %h expected 00000000", cpu_rdata); end
    n_checks++; if (ram_wr_cnt !== 0) begin n_errors++; $display("FAIL reset_no_write: got %0d writes expected 0", ram_wr_cnt); end
    @(negedge clk);
    cpu_wmask = 4'h0; dma_req = 1'b0; dma_wmask = 4'h0;
    reset = 1'b0;
    #1;
    n_checks++; if (ram_en !== 1'b1) begin n_errors++; $display("FAIL first_access_en: got %b expected 1", ram_en); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_errors++; $display("FAIL first_access_hold: got %b expected 1", cpu_hold); end
  endtask

  task automatic test_cpu_alone();
    logic exp_hold;
    ram_mem[0] = 32'h1111_1111;
    cpu_addr = 32'h0; cpu_wmask = 4'h0; dma_req = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_hold = (i % 2 == 0);
      n_checks++;
      if (cpu_hold !== exp_hold) begin n_errors++; $display("FAIL cpu_alone_hold[%0d]: got %b expected %b", i, cpu_hold, exp_hold); end
      if (!exp_hold) begin
        n_checks++;
        if (cpu_rdata !== 32'h1111_1111) begin n_errors++; $display("FAIL cpu_alone_rdata[%0d]: got %h expected 11111111", i, cpu_rdata); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cpu_store();
    int wr0;
    ram_mem[1] = 32'h1234_5678;
    cpu_addr = 32'h6; cpu_wmask = 4'b1100; cpu_wdata = 32'hABCD_0000; dma_req = 1'b0;
    do_reset();
    wr0 = ram_wr_cnt;
    #1;
    n_checks++; if (ram_wmask !== 4'b1100) begin n_errors++; $display("FAIL store_issue_wmask: got %b expected 1100", ram_wmask); end
    n_checks++; if (ram_addr !== 12'd1) begin n_errors++; $display("FAIL store_issue_addr: got %0d expected 1", ram_addr); end
    @(negedge clk); #1;
    n_checks++; if (cpu_hold !== 1'b0) begin n_errors++; $display("FAIL store_rsp_hold: got %b expected 0", cpu_hold); end
    n_checks++; if (ram_wmask !== 4'b0000) begin n_errors++; $display("FAIL store_rsp_wmask: got %b expected 0000", ram_wmask); end
    // Core moves on to a plain read after its step.
    @(negedge clk);
    cpu_addr = 32'h0; cpu_wmask = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (ram_wr_cnt - wr0 !== 1) begin n_errors++; $display("FAIL store_once: got %0d writes expected 1", ram_wr_cnt - wr0); end
    n_checks++; if (ram_mem[1] !== 32'hABCD_5678) begin n_errors++; $display("FAIL store_data: got %h expected abcd5678", ram_mem[1]); end
  endtask

  task automatic test_dma_burst();
    int   k;
    logic exp_ack, exp_hold;
    cpu_addr = 32'h0; cpu_wmask = 4'h0;
    dma_req = 1'b1; dma_addr = 32'h10; dma_wmask = 4'h0;
    do_reset();
    for (int i = 0; i < 2 * SLOT; i++) begin
      #1;
      k        = i % SLOT;
      exp_ack  = (k < 2 * BURST) && (k % 2 == 1);
      exp_hold = (k != SLOT - 1);
      n_checks++;
      if (dma_ack !== exp_ack) begin n_errors++; $display("FAIL burst_ack[%0d]: got %b expected %b", i, dma_ack, exp_ack); end
      n_checks++;
      if (cpu_hold !== exp_hold) begin n_errors++; $display("FAIL burst_hold[%0d]: got %b expected %b", i, cpu_hold, exp_hold); end
      @(negedge clk);
    end
    dma_req = 1'b0;
  endtask

  task automatic test_dma_priority();
    logic got_dma, got_cpu;
    int   ack_cyc;
    ram_mem[0]  = 32'h1111_1111;
    ram_mem[16] = 32'hDEAD_BEEF;
    cpu_addr = 32'h0; cpu_wmask = 4'h0;
    dma_req = 1'b1; dma_addr = 32'h40; dma_wmask = 4'h0;
    do_reset();
    got_dma = 1'b0; got_cpu = 1'b0; ack_cyc = -1;
    for (int i = 0; i < 8 && !got_cpu; i++) begin
      #1;
      if (dma_ack === 1'b1 && !got_dma) begin
        got_dma = 1'b1; ack_cyc = i;
        n_checks++;
        if (dma_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL prio_dma_rdata: got %h expected deadbeef", dma_rdata); end
        dma_req = 1'b0;
      end
      if (cpu_hold === 1'b0) begin
        got_cpu = 1'b1;
        n_checks++;
        if (!got_dma) begin n_errors++; $display("FAIL prio_order: got cpu first expected dma first"); end
        n_checks++;
        if (cpu_rdata !== 32'h1111_1111) begin n_errors++; $display("FAIL prio_cpu_rdata: got %h expected 11111111", cpu_rdata); end
      end
      @(negedge clk);
    end
    dma_req = 1'b0;
    n_checks++; if (!got_cpu) begin n_errors++; $display("FAIL prio_cpu_timeout: got no cpu step expected one within 8 cycles"); end
    n_checks++; if (ack_cyc != 1) begin n_errors++; $display("FAIL prio_latency: got ack at cycle %0d expected 1", ack_cyc); end
  endtask

  task automatic test_reset_in_dma();
    int   wr0, wr_snap, acks;
    logic seen_slot;
    cpu_addr = 32'h0; cpu_wmask = 4'h0;
    dma_req = 1'b1; dma_addr = 32'h80; dma_wmask = 4'hF; dma_wdata = 32'hCAFE_F00D;
    do_reset();
    wr0 = ram_wr_cnt;
    @(negedge clk);              // write issued; DUT now in the DMA response cycle
    reset = 1'b1;
    #1;
    wr_snap = ram_wr_cnt;
    n_checks++; if (wr_snap - wr0 !== 1) begin n_errors++; $display("FAIL rdma_issue: got %0d writes expected 1", wr_snap - wr0); end
    n_checks++; if (dma_ack !== 1'b0) begin n_errors++; $display("FAIL rdma_ack: got %b expected 0", dma_ack); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_errors++; $display("FAIL rdma_hold: got %b expected 1", cpu_hold); end
    @(negedge clk); #1;
    n_checks++; if (ram_en !== 1'b0 || ram_wmask !== 4'b0000) begin n_errors++; $display("FAIL rdma_ram_idle: got en=%b wmask=%b expected en=0 wmask=0000", ram_en, ram_wmask); end
    @(negedge clk);
    n_checks++; if (ram_wr_cnt !== wr_snap) begin n_errors++; $display("FAIL rdma_no_write: got %0d writes expected %0d", ram_wr_cnt, wr_snap); end
    // Credit must be full again: a held read request gets BURST acks first.
    dma_wmask = 4'h0;
    reset = 1'b0;
    acks = 0; seen_slot = 1'b0;
    for (int i = 0; i < 2 * SLOT && !seen_slot; i++) begin
      #1;
      if (dma_ack === 1'b1) acks++;
      if (cpu_hold === 1'b0) seen_slot = 1'b1;
      @(negedge clk);
    end
    dma_req = 1'b0;
    n_checks++; if (!seen_slot) begin n_errors++; $display("FAIL rdma_slot_timeout: got no cpu step expected one"); end
    n_checks++; if (acks != BURST) begin n_errors++; $display("FAIL rdma_credit: got %0d acks expected %0d", acks, BURST); end
  endtask

  task automatic test_alias();
    ram_mem[2] = 32'hA5A5_0002;
    cpu_addr = 32'h4000_0008; cpu_wmask = 4'h0; dma_req = 1'b0;
    do_reset();
    #1;
    n_checks++; if (ram_addr !== 12'd2) begin n_errors++; $display("FAIL alias_addr: got %0d expected 2", ram_addr); end
    @(negedge clk); #1;
    n_checks++; if (cpu_rdata !== 32'hA5A5_0002) begin n_errors++; $display("FAIL alias_rdata: got %h expected a5a50002", cpu_rdata); end
  endtask

  // Random CPU and DMA traffic judged at transaction level: every completed
  // read must match the shadow memory, every store must hit RAM exactly once,
  // the DMA never gets more than BURST accesses between CPU steps, a DMA
  // request completes within 4 cycles and the CPU steps at least every SLOT.
  task automatic test_random(input int cycles);
    int          c_idx, d_idx, d_lat, gap, since_cpu, exp_wr, wr0;
    logic        d_pend;
    logic [31:0] v;
    for (int i = 0; i < RGN; i++) begin
      v = $urandom(); ram_mem[i] = v; exp_mem[i] = v;
    end
    c_idx     = $urandom_range(0, RGN - 1);
    cpu_addr  = ($urandom() & 32'hFFFF_C000) | (c_idx << 2) | $urandom_range(0, 3);
    cpu_wmask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    cpu_wdata = $urandom();
    dma_req   = 1'b0;
    d_pend = 1'b0; d_idx = 0; d_lat = 0; gap = 0; since_cpu = 0; exp_wr = 0;
    do_reset();
    wr0 = ram_wr_cnt;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      #1;
      gap++;
      if (d_pend) d_lat++;
      if (cpu_hold === 1'b0) begin
        n_checks++;
        if (gap > SLOT) begin n_errors++; $display("FAIL rnd_cpu_gap: got %0d cycles expected <= %0d", gap, SLOT); end
        gap = 0; since_cpu = 0;
        if (cpu_wmask == 4'h0) begin
          n_checks++;
          if (cpu_rdata !== exp_mem[c_idx]) begin n_errors++; $display("FAIL rnd_cpu_rdata: got %h expected %h (word %0d)", cpu_rdata, exp_mem[c_idx], c_idx); end
        end else begin
          for (int b = 0; b < 4; b++)
            if (cpu_wmask[b]) exp_mem[c_idx][8*b +: 8] = cpu_wdata[8*b +: 8];
          exp_wr++;
        end
        c_idx     = $urandom_range(0, RGN - 1);
        cpu_addr  = ($urandom() & 32'hFFFF_C000) | (c_idx << 2) | $urandom_range(0, 3);
        cpu_wmask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        cpu_wdata = $urandom();
      end
      if (dma_ack === 1'b1) begin
        n_checks++;
        if (!d_pend) begin
          n_errors++; $display("FAIL rnd_dma_spurious: got ack expected none");
        end else begin
          since_cpu++;
          n_checks++;
          if (since_cpu > BURST) begin n_errors++; $display("FAIL rnd_dma_burst: got %0d acks expected <= %0d", since_cpu, BURST); end
          n_checks++;
          if (d_lat > 4) begin n_errors++; $display("FAIL rnd_dma_latency: got %0d expected <= 4", d_lat); end
          if (dma_wmask == 4'h0) begin
            n_checks++;
            if (dma_rdata !== exp_mem[d_idx]) begin n_errors++; $display("FAIL rnd_dma_rdata: got %h expected %h (word %0d)", dma_rdata, exp_mem[d_idx], d_idx); end
          end else begin
            for (int b = 0; b < 4; b++)
              if (dma_wmask[b]) exp_mem[d_idx][8*b +: 8] = dma_wdata[8*b +: 8];
            exp_wr++;
          end
          d_pend = 1'b0; dma_req = 1'b0;
        end
      end else if (d_pend && d_lat > 4) begin
        n_checks++; n_errors++;
        $display("FAIL rnd_dma_timeout: got no ack after %0d cycles expected <= 4", d_lat);
        d_pend = 1'b0; dma_req = 1'b0;
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_idx     = $urandom_range(0, RGN - 1);
        dma_addr  = ($urandom() & 32'hFFFF_C000) | (d_idx << 2) | $urandom_range(0, 3);
        dma_wmask = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        dma_wdata = $urandom();
        dma_req   = 1'b1;
        d_pend    = 1'b1;
        d_lat     = 0;
      end
      @(negedge clk);
    end
    dma_req = 1'b0;
    cpu_wmask = 4'h0;
    #1;
    n_checks++;
    if (ram_wr_cnt - wr0 !== exp_wr) begin n_errors++; $display("FAIL rnd_write_count: got %0d expected %0d", ram_wr_cnt - wr0, exp_wr); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = 32'h0;
    test_reset();
    test_cpu_alone();
    test_cpu_store();
    test_dma_burst();
    test_dma_priority();
    test_reset_in_dma();
    test_alias();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
